pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/flush sequencer for the 5-stage MIPS pipeline.
- Drives the enable and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable.
- Resolves load-use hazards, taken branches/jumps, instruction-cache misses, data-cache waits and halt drain.
- Sits beside the datapath; it holds no data, only control.

Parameters:
- DRAIN_CYCLES, 2, cycles MEM/WB keeps advancing after halt reaches MEM before halted asserts (1..15)
- REGW, 5, register index width

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- ihit  in  1  instruction fetch complete this cycle
- dhit  in  1  data access complete this cycle
- mem_dren  in  1  EX/MEM stage holds a load
- mem_dwen  in  1  EX/MEM stage holds a store
- mem_pcsrc  in  1  branch taken, or J/JAL/JR resolved in MEM stage
- mem_halt  in  1  halt instruction in MEM stage
- ex_dren  in  1  ID/EX stage holds a load
- ex_rt  in  REGW  load destination in ID/EX
- id_rs  in  REGW  rs of instruction in IF/ID
- id_rt  in  REGW  rt of instruction in IF/ID
- id_uses_rt  in  1  IF/ID instruction reads rt
- pc_en  out  1  PC update enable
- ifid_en, idex_en, exmem_en, memwb_en  out  1 each  latch enables
- ifid_flush, idex_flush, exmem_flush  out  1 each  latch flush (bubble insert)
- halted  out  1  sticky halt indication

Behaviour:
- States: RUN, MEMWAIT, DRAIN, HALTED. Reset state: RUN, drain counter 0, halted 0.
- While nRST is low, all enables are 0, all flushes are 0 and halted is 0.
- All outputs are combinational from state and inputs. Only the state, the counter and halted are registered.
- mem_req = mem_dren | mem_dwen.
- Hazards are evaluated in RUN, highest priority first:
  - 1. mem_halt: pc_en=0; ifid/idex/exmem flush=1 and their enables=1; memwb_en=1. Next state DRAIN, counter loads DRAIN_CYCLES-1.
  - 2. mem_req & !dhit: all enables 0, all flushes 0. Next state MEMWAIT.
  - 3. mem_pcsrc: all enables 1; ifid_flush, idex_flush and exmem_flush=1; pc_en=1 (PC takes the branch target).
  - 4. Load-use, defined as ex_dren & ex_rt!=0 & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)): pc_en=0, ifid_en=0, idex_flush=1; exmem_en and memwb_en=1. One bubble only.
  - 5. !ihit: pc_en=0, ifid_flush=1; downstream enables 1.
  - 6. Otherwise all enables 1 and all flushes 0.
- MEMWAIT:
  - While !dhit, everything is frozen (enables 0).
  - On dhit, the cycle is evaluated exactly as RUN rules 3-6 (the memory access completes and the pipe advances). Next state RUN.
  - mem_halt cannot be asserted in MEMWAIT, because a halt never carries a memory request.
- DRAIN:
  - pc_en=0; ifid/idex/exmem enables 1 with flush 1; memwb_en=1; ihit, dhit and hazard inputs are ignored.
  - The counter decrements each cycle. At 0 the next state is HALTED and halted<=1.
  - DRAIN_CYCLES=1 means HALTED is reached the cycle after mem_halt.
- HALTED: all enables 0, flushes 0, halted=1. The only exit is reset.
- Simultaneous mem_pcsrc and load-use: the flush wins, and no stall is inserted (the load is squashed).
- ex_rt==0 never stalls.
- Reset asserted mid-MEMWAIT or mid-DRAIN returns to RUN immediately (asynchronously), with the counter cleared.

Optional Feature:
- Macro: HAZARD_STALL_CNT_EN.
- Defined: adds outputs stall_cycles[31:0] and flush_events[31:0], both reset to 0.
  - stall_cycles increments every cycle in which pc_en=0 while in RUN or MEMWAIT.
  - flush_events increments on every mem_pcsrc flush cycle.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Load-use: ex_dren=1, ex_rt=5'd8, id_rs=5'd8, ihit=1 -> exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle all enables 1.
- Zero-register load: ex_dren=1, ex_rt=0, id_rs=0 -> no stall; pc_en=1.
- Data wait: mem_dren=1 with dhit held low 3 cycles -> 3 cycles all enables 0; dhit=1 on cycle 4 -> enables 1, state back to RUN.
- Flush priority: mem_pcsrc=1 together with a load-use match -> ifid/idex/exmem flush=1, pc_en=1, no stall cycle.
- Halt: mem_halt=1 with DRAIN_CYCLES=2 -> 2 cycles with memwb_en=1 and pc_en=0; halted=1 from cycle 3 and stays 1; reset clears it to 0.
- Counters (HAZARD_STALL_CNT_EN defined): one load-use stall, one 2-cycle dwait and one branch flush -> stall_cycles=3, flush_events=1.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Handshake bundle between the pipeline datapath and the hazard sequencer.
// Counter outputs exist only when HAZARD_STALL_CNT_EN is defined.
interface pipe_hazard_ctrl_if #(parameter int REGW = 5);
  logic            ihit;
  logic            dhit;
  logic            mem_dren;
  logic            mem_dwen;
  logic            mem_pcsrc;
  logic            mem_halt;
  logic            ex_dren;
  logic [REGW-1:0] ex_rt;
  logic [REGW-1:0] id_rs;
  logic [REGW-1:0] id_rt;
  logic            id_uses_rt;
  logic            pc_en;
  logic            ifid_en;
  logic            idex_en;
  logic            exmem_en;
  logic            memwb_en;
  logic            ifid_flush;
  logic            idex_flush;
  logic            exmem_flush;
  logic            halted;
`ifdef HAZARD_STALL_CNT_EN
  logic [31:0]     stall_cycles;
  logic [31:0]     flush_events;

  modport master (
    output ihit, dhit, mem_dren, mem_dwen, mem_pcsrc, mem_halt,
           ex_dren, ex_rt, id_rs, id_rt, id_uses_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted,
           stall_cycles, flush_events
  );

  modport slave (
    input  ihit, dhit, mem_dren, mem_dwen, mem_pcsrc, mem_halt,
           ex_dren, ex_rt, id_rs, id_rt, id_uses_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted,
           stall_cycles, flush_events
  );
`else
  modport master (
    output ihit, dhit, mem_dren, mem_dwen, mem_pcsrc, mem_halt,
           ex_dren, ex_rt, id_rs, id_rt, id_uses_rt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted
  );

  modport slave (
    input  ihit, dhit, mem_dren, mem_dwen, mem_pcsrc, mem_halt,
           ex_dren, ex_rt, id_rs, id_rt, id_uses_rt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_flush, idex_flush, exmem_flush, halted
  );
`endif
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline latches and PC enable.
// Optional HAZARD_STALL_CNT_EN adds saturating stall/flush event counters.
//
// state   | meaning
// RUN     | normal issue, hazards resolved by priority
// MEMWAIT | data access outstanding, pipe frozen until dhit
// DRAIN   | halt in flight, MEM/WB still retiring, front end flushed
// HALTED  | sticky stop, left only through reset
module pipe_hazard_ctrl #(
  parameter int DRAIN_CYCLES = 2,
  parameter int REGW         = 5
) (
  input logic           CLK,
  input logic           nRST,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

  // The mem_halt cycle is the first drain cycle, so the counter covers the rest.
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic       halted_r, halted_n;

  logic            mem_req;
  logic            load_use;
  logic [REGW-1:0] ex_rt, id_rs, id_rt;

  logic c_pc_en, c_ifid_en, c_idex_en, c_exmem_en, c_memwb_en;
  logic c_ifid_flush, c_idex_flush, c_exmem_flush;
  logic adv;

  assign ex_rt    = hz.ex_rt;
  assign id_rs    = hz.id_rs;
  assign id_rt    = hz.id_rt;
  assign mem_req  = hz.mem_dren | hz.mem_dwen;
  assign load_use = hz.ex_dren && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (hz.id_uses_rt && (ex_rt == id_rt)));

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= RUN;
      cnt      <= '0;
      halted_r <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      halted_r <= halted_n;
    end
  end

  always_comb begin
    state_n       = state;
    cnt_n         = cnt;
    halted_n      = halted_r;
    adv           = 1'b0;
    c_pc_en       = 1'b0;
    c_ifid_en     = 1'b0;
    c_idex_en     = 1'b0;
    c_exmem_en    = 1'b0;
    c_memwb_en    = 1'b0;
    c_ifid_flush  = 1'b0;
    c_idex_flush  = 1'b0;
    c_exmem_flush = 1'b0;

    case (state)
      RUN: begin
        if (hz.mem_halt) begin
          c_ifid_en     = 1'b1;
          c_idex_en     = 1'b1;
          c_exmem_en    = 1'b1;
          c_memwb_en    = 1'b1;
          c_ifid_flush  = 1'b1;
          c_idex_flush  = 1'b1;
          c_exmem_flush = 1'b1;
          if (DRAIN_LOAD == 4'd0) begin
            state_n  = HALTED;
            halted_n = 1'b1;
          end else begin
            state_n = DRAIN;
            cnt_n   = DRAIN_LOAD;
          end
        end else if (mem_req && !hz.dhit) begin
          state_n = MEMWAIT;
        end else begin
          adv = 1'b1;
        end
      end
      MEMWAIT: begin
        if (hz.dhit) begin
          adv     = 1'b1;
          state_n = RUN;
        end
      end
      DRAIN: begin
        c_ifid_en     = 1'b1;
        c_idex_en     = 1'b1;
        c_exmem_en    = 1'b1;
        c_memwb_en    = 1'b1;
        c_ifid_flush  = 1'b1;
        c_idex_flush  = 1'b1;
        c_exmem_flush = 1'b1;
        cnt_n         = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          state_n  = HALTED;
          halted_n = 1'b1;
          cnt_n    = '0;
        end
      end
      HALTED: begin
        halted_n = 1'b1;
      end
      default: begin
        state_n = RUN;
      end
    endcase

    // Shared by RUN and the completing MEMWAIT cycle.
    if (adv) begin
      c_ifid_en  = 1'b1;
      c_idex_en  = 1'b1;
      c_exmem_en = 1'b1;
      c_memwb_en = 1'b1;
      c_pc_en    = 1'b1;
      if (hz.mem_pcsrc) begin
        c_ifid_flush  = 1'b1;
        c_idex_flush  = 1'b1;
        c_exmem_flush = 1'b1;
      end else if (load_use) begin
        c_pc_en      = 1'b0;
        c_ifid_en    = 1'b0;
        c_idex_flush = 1'b1;
      end else if (!hz.ihit) begin
        c_pc_en      = 1'b0;
        c_ifid_flush = 1'b1;
      end
    end
  end

  assign hz.pc_en       = nRST & c_pc_en;
  assign hz.ifid_en     = nRST & c_ifid_en;
  assign hz.idex_en     = nRST & c_idex_en;
  assign hz.exmem_en    = nRST & c_exmem_en;
  assign hz.memwb_en    = nRST & c_memwb_en;
  assign hz.ifid_flush  = nRST & c_ifid_flush;
  assign hz.idex_flush  = nRST & c_idex_flush;
  assign hz.exmem_flush = nRST & c_exmem_flush;
  assign hz.halted      = nRST & halted_r;

`ifdef HAZARD_STALL_CNT_EN
  logic [31:0] stall_cycles, flush_events;
  logic        stall_evt, flush_evt;

  assign stall_evt = ((state == RUN) || (state == MEMWAIT)) && !c_pc_en;
  assign flush_evt = adv && hz.mem_pcsrc;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall_evt && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush_evt && (flush_events != 32'hFFFF_FFFF))
        flush_events <= flush_events + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_cycles;
  assign hz.flush_events = flush_events;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed scoreboard bench for pipe_hazard_ctrl (DRAIN_CYCLES=2).
module tb_pipe_hazard_ctrl;

  logic CLK = 1'b0;
  logic nRST;
  int   total = 0;
  int   bad   = 0;

  always #5 CLK = ~CLK;

  pipe_hazard_ctrl_if #(.REGW(5)) hz ();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .REGW(5)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .hz   (hz)
  );

  // {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush}
  localparam logic [7:0] V_OFF   = 8'b0000_0000;
  localparam logic [7:0] V_RUN   = 8'b1111_1000;
  localparam logic [7:0] V_LU    = 8'b0011_1010;
  localparam logic [7:0] V_BR    = 8'b1111_1111;
  localparam logic [7:0] V_IMISS = 8'b0111_1100;
  localparam logic [7:0] V_DRAIN = 8'b0111_1111;

  typedef struct {
    logic [7:0] vec;
    logic       hlt;
    string      tag;
  } exp_t;

  exp_t sb[$];
  logic [7:0] obs;

  assign obs = {hz.pc_en, hz.ifid_en, hz.idex_en, hz.exmem_en, hz.memwb_en,
                hz.ifid_flush, hz.idex_flush, hz.exmem_flush};

  task automatic idle();
    hz.ihit = 1'b1; hz.dhit = 1'b1;
    hz.mem_dren = 1'b0; hz.mem_dwen = 1'b0; hz.mem_pcsrc = 1'b0; hz.mem_halt = 1'b0;
    hz.ex_dren = 1'b0; hz.ex_rt = '0; hz.id_rs = '0; hz.id_rt = '0; hz.id_uses_rt = 1'b0;
  endtask

  task automatic expect_out(input logic [7:0] v, input logic h, input string tag);
    exp_t e;
    e.vec = v; e.hlt = h; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL sb_empty: got no expectation, required one");
      return;
    end
    e = sb.pop_front();
    total++;
    assert (obs === e.vec) else begin
      bad++;
      $error("FAIL %s: ctl got %b required %b", e.tag, obs, e.vec);
    end
    total++;
    assert (hz.halted === e.hlt) else begin
      bad++;
      $error("FAIL %s_halted: got %b required %b", e.tag, hz.halted, e.hlt);
    end
  endtask

  // Inputs are already driven (just after posedge); sample at negedge, then advance.
  task automatic cyc(input logic [7:0] v, input logic h, input string tag);
    expect_out(v, h, tag);
    @(negedge CLK);
    check_now();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nRST = 1'b0;
    idle();
    hz.ex_dren = 1'b1; hz.ex_rt = 5'd8; hz.id_rs = 5'd8;
    repeat (2) @(posedge CLK);
    #1;
    expect_out(V_OFF, 1'b0, "reset_hold");
    check_now();
    idle();
    @(negedge CLK);
    nRST = 1'b1;
    @(posedge CLK);
    #1;

    cyc(V_RUN, 1'b0, "idle");

    // load-use on rs, then the load moves on
    hz.ex_dren = 1'b1; hz.ex_rt = 5'd8; hz.id_rs = 5'd8;
    cyc(V_LU, 1'b0, "lu_rs");
    idle();
    cyc(V_RUN, 1'b0, "lu_after");

    hz.ex_dren = 1'b1; hz.ex_rt = 5'd9; hz.id_rs = 5'd3; hz.id_rt = 5'd9; hz.id_uses_rt = 1'b1;
    cyc(V_LU, 1'b0, "lu_rt");
    hz.id_uses_rt = 1'b0;
    cyc(V_RUN, 1'b0, "lu_rt_unused");

    idle();
    hz.ex_dren = 1'b1; hz.ex_rt = 5'd0; hz.id_rs = 5'd0;
    cyc(V_RUN, 1'b0, "lu_zero_reg");

    idle();
    hz.ihit = 1'b0;
    cyc(V_IMISS, 1'b0, "imiss");

    // data wait, three frozen cycles then completion
    idle();
    hz.mem_dren = 1'b1; hz.dhit = 1'b0;
    cyc(V_OFF, 1'b0, "dwait_1");
    cyc(V_OFF, 1'b0, "dwait_2");
    hz.mem_pcsrc = 1'b1;
    cyc(V_OFF, 1'b0, "dwait_3_frozen");
    hz.mem_pcsrc = 1'b0; hz.dhit = 1'b1;
    cyc(V_RUN, 1'b0, "dwait_done");
    idle();
    hz.dhit = 1'b0;
    cyc(V_RUN, 1'b0, "dwait_back_run");

    // store wait resolving together with a branch
    idle();
    hz.mem_dwen = 1'b1; hz.dhit = 1'b0;
    cyc(V_OFF, 1'b0, "swait");
    hz.dhit = 1'b1; hz.mem_pcsrc = 1'b1;
    cyc(V_BR, 1'b0, "swait_branch");

    idle();
    hz.mem_pcsrc = 1'b1; hz.ex_dren = 1'b1; hz.ex_rt = 5'd8; hz.id_rs = 5'd8;
    cyc(V_BR, 1'b0, "flush_over_lu");
    idle();
    cyc(V_RUN, 1'b0, "flush_after");

    // halt and drain
    hz.mem_halt = 1'b1;
    cyc(V_DRAIN, 1'b0, "halt_1");
    idle();
    hz.ihit = 1'b0; hz.dhit = 1'b0; hz.mem_dren = 1'b1; hz.mem_pcsrc = 1'b1;
    cyc(V_DRAIN, 1'b0, "halt_2");
    cyc(V_OFF, 1'b1, "halted_3");
    idle();
    hz.mem_pcsrc = 1'b1;
    cyc(V_OFF, 1'b1, "halted_4");
    idle();
    cyc(V_OFF, 1'b1, "halted_5");

    #2 nRST = 1'b0;
    #1;
    expect_out(V_OFF, 1'b0, "halted_reset");
    check_now();
    #1 nRST = 1'b1;
    @(posedge CLK);
    #1;
    cyc(V_RUN, 1'b0, "post_halt_run");

    // reset in the middle of a drain
    hz.mem_halt = 1'b1;
    cyc(V_DRAIN, 1'b0, "drain_enter");
    idle();
    nRST = 1'b0;
    #1;
    expect_out(V_OFF, 1'b0, "drain_reset");
    check_now();
    #1 nRST = 1'b1;
    cyc(V_RUN, 1'b0, "drain_reset_run");

    // reset in the middle of a data wait
    hz.mem_dren = 1'b1; hz.dhit = 1'b0;
    cyc(V_OFF, 1'b0, "mw_enter");
    nRST = 1'b0;
    #1;
    expect_out(V_OFF, 1'b0, "mw_reset");
    check_now();
    #1 nRST = 1'b1;
    idle();
    hz.dhit = 1'b0;
    cyc(V_RUN, 1'b0, "mw_reset_run");

`ifdef HAZARD_STALL_CNT_EN
    idle();
    nRST = 1'b0;
    #2;
    total++;
    assert (hz.stall_cycles === 32'd0 && hz.flush_events === 32'd0) else begin
      bad++;
      $error("FAIL cnt_reset: got %0d/%0d required 0/0", hz.stall_cycles, hz.flush_events);
    end
    nRST = 1'b1;
    @(posedge CLK);
    #1;
    hz.ex_dren = 1'b1; hz.ex_rt = 5'd8; hz.id_rs = 5'd8;
    cyc(V_LU, 1'b0, "cnt_lu");
    idle();
    hz.mem_dren = 1'b1; hz.dhit = 1'b0;
    cyc(V_OFF, 1'b0, "cnt_dw1");
    cyc(V_OFF, 1'b0, "cnt_dw2");
    hz.dhit = 1'b1;
    cyc(V_RUN, 1'b0, "cnt_dw_done");
    idle();
    hz.mem_pcsrc = 1'b1;
    cyc(V_BR, 1'b0, "cnt_br");
    idle();
    cyc(V_RUN, 1'b0, "cnt_idle");
    @(negedge CLK);
    total++;
    assert (hz.stall_cycles === 32'd3) else begin
      bad++;
      $error("FAIL cnt_stall: got %0d required 3", hz.stall_cycles);
    end
    total++;
    assert (hz.flush_events === 32'd1) else begin
      bad++;
      $error("FAIL cnt_flush: got %0d required 1", hz.flush_events);
    end
`endif

    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover: got %0d required 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
